// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Optional signed-overflow output is enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// The ovf wire exists only when SERIAL_SUBTRACTOR_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, borrow, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full-subtractor cell.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow result bit.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH  // must be >= 2
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             bq;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             d;
  logic             bn;

  full_subtractor u_cell (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (bq),
    .d    (d),
    .bout (bn)
  );

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Operand MSBs are shifted out of sa/sb, so keep copies for the overflow term.
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state == ST_IDLE && bus.start) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if (state == ST_SHIFT && cnt == CW'(WIDTH - 1)) begin
      ovf_q <= (a_msb ^ b_msb) & (a_msb ^ d);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours (sa/sb/sd shift together).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sa       <= '0;
      sb       <= '0;
      sd       <= '0;
      bq       <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            sa    <= bus.a;
            sb    <= bus.b;
            bq    <= 1'b0;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sd  <= {d, sd[WIDTH-1:1]};
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          bq  <= bn;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // Result registers load on the edge into DONE so they are valid while done is high.
            diff_q   <= {d, sd[WIDTH-1:1]};
            borrow_q <= bn;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != ST_IDLE);
  assign bus.done   = (state == ST_DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 instance with a result scoreboard,
// plus a WIDTH=3 instance swept over all operand pairs.
module tb_serial_subtractor;

  localparam int W = 8;
  localparam int BUDGET = 40;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor_if #(.WIDTH(3)) bus3 ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t m;
    m.diff   = a - b;
    m.borrow = (a < b);
    m.ovf    = (a[W-1] ^ b[W-1]) & (a[W-1] ^ m.diff[W-1]);
    return m;
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    sb_q.push_back(model(a, b));
  endtask

  task automatic score(input string tag);
    exp_t e;
    check({tag, "_pending"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_diff"}, 32'(bus.diff), 32'(e.diff));
      check({tag, "_borrow"}, 32'(bus.borrow), 32'(e.borrow));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
`endif
    end
  endtask

  // Single-cycle start already driven; returns cycles until done (0 if it never came).
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    for (int i = 1; i <= BUDGET; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
      end
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(W + 1));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    launch(a, b);
    wait_done(tag, lat);
    if (lat != 0) score(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int done_cnt;
    int first_done;
    int second_done;
    logic [2:0] exp3;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus3.start = 1'b0;
    bus3.a     = '0;
    bus3.b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_diff", 32'(bus.diff), 32'd0);
    check("reset_borrow", 32'(bus.borrow), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("reset_ovf", 32'(bus.ovf), 32'd0);
`endif
    rst = 1'b0;

    run_op("5m3", 8'h05, 8'h03);
    run_op("3m5", 8'h03, 8'h05);
    run_op("80m01", 8'h80, 8'h01);
    run_op("10m01", 8'h10, 8'h01);
    run_op("7fmff", 8'h7F, 8'hFF);

    // A second start three cycles into SHIFT must be ignored.
    launch(8'h40, 8'h11);
    done_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 3) begin
        bus.start = 1'b1;
        bus.a     = 8'h22;
        bus.b     = 8'h99;
      end
      if (i == 4) bus.start = 1'b0;
      if (bus.done) begin
        done_cnt++;
        score("ignored_start");
      end
    end
    check("ignored_start_done_count", 32'(done_cnt), 32'd1);

    // Start held high relaunches on the first IDLE cycle; operands change mid-operation.
    launch(8'h30, 8'h0F);
    first_done  = 0;
    second_done = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus.a = 8'h01;
        bus.b = 8'h02;
        sb_q.push_back(model(8'h01, 8'h02));
      end
      if (i == 10) check("held_idle_gap", 32'(bus.busy), 32'd0);
      if (i == 11) bus.start = 1'b0;
      if (bus.done) begin
        if (first_done == 0) first_done = i;
        else second_done = i;
        score("held_start");
      end
    end
    check("held_first_done", 32'(first_done), 32'(W + 1));
    check("held_second_done", 32'(second_done), 32'(2 * W + 3));

    // Reset four cycles into SHIFT abandons the operation and clears the result.
    launch(8'h77, 8'h11);
    done_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 5) rst = 1'b1;
      if (i == 6) rst = 1'b0;
      if (bus.done) done_cnt++;
    end
    sb_q.delete();
    check("rst_mid_done_count", 32'(done_cnt), 32'd0);
    check("rst_mid_diff", 32'(bus.diff), 32'd0);
    check("rst_mid_borrow", 32'(bus.borrow), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    run_op("ffmff", 8'hFF, 8'hFF);

    // WIDTH=3: every operand pair.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        @(negedge clk);
        bus3.a     = 3'(a);
        bus3.b     = 3'(b);
        bus3.start = 1'b1;
        done_cnt   = 0;
        for (int i = 1; i <= BUDGET; i++) begin
          @(negedge clk);
          if (i == 1) bus3.start = 1'b0;
          if (bus3.done) begin
            done_cnt = i;
            break;
          end
        end
        exp3 = 3'(a - b);
        check("w3_latency", 32'(done_cnt), 32'd4);
        check("w3_diff", 32'(bus3.diff), 32'(exp3));
        check("w3_borrow", 32'(bus3.borrow), 32'(a < b));
      end
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
